// File: rtl/sevenseg_scan_array.sv
// Multiplexed seven-segment driver for NUM_DISP displays of DIGITS digits sharing one scan counter.
// Double-buffered loads commit at frame boundaries; supports leading-zero blanking and PWM brightness.
module sevenseg_scan_array #(
    parameter int NUM_DISP       = 3,
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0,
    localparam int DW            = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [DW-1:0]              load_disp,
    input  logic [4*DIGITS-1:0]        load_value,
    input  logic                       load_blank_lz,
    input  logic [3:0]                 brightness,
    output logic [NUM_DISP*DIGITS-1:0] anode_en,
    output logic [NUM_DISP*7-1:0]      seg_out
);
    localparam int PCW = $clog2(SCAN_DIV);
    localparam int DIW = $clog2(DIGITS);
    localparam int PW  = PCW + 5;
    localparam int TW  = PCW + 1;

    logic [PCW-1:0]       pc;
    logic [DIW-1:0]       di;
    logic [TW-1:0]        thr_latched;
    logic [TW-1:0]        thr_now;
    logic [TW-1:0]        thr_eff;
    logic [PW-1:0]        thr_prod;
    logic                 pc_wrap;
    logic                 frame_end;
    logic                 lit;
    logic                 accept;

    logic [4*DIGITS-1:0]  shadow_val [NUM_DISP];
    logic [4*DIGITS-1:0]  active_val [NUM_DISP];
    logic [NUM_DISP-1:0]  shadow_blz;
    logic [NUM_DISP-1:0]  active_blz;
    logic [NUM_DISP-1:0]  pending;

    logic [NUM_DISP*DIGITS-1:0] an_next;
    logic [NUM_DISP*7-1:0]      seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h00;
        case (v)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    assign pc_wrap   = (pc == PCW'(SCAN_DIV - 1));
    assign frame_end = pc_wrap && (di == DIW'(DIGITS - 1));

    // Full-width product so brightness=15 yields exactly SCAN_DIV (whole slot lit).
    assign thr_prod = (PW'(brightness) + PW'(1)) * PW'(SCAN_DIV);
    assign thr_now  = TW'(thr_prod >> 4);
    // On the pc==0 cycle the freshly sampled threshold applies to the slot being started.
    assign thr_eff  = (pc == '0) ? thr_now : thr_latched;
    assign lit      = ({1'b0, pc} < thr_eff);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= '0;
            di          <= '0;
            thr_latched <= '0;
        end else begin
            if (pc_wrap) begin
                pc <= '0;
                di <= (di == DIW'(DIGITS - 1)) ? '0 : di + DIW'(1);
            end else begin
                pc <= pc + PCW'(1);
            end
            if (pc == '0) thr_latched <= thr_now;
        end
    end

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        load_ready = 1'b0;
        for (int d = 0; d < NUM_DISP; d++) begin
            if (load_disp == DW'(d) && !pending[d]) load_ready = 1'b1;
        end
    end

    assign accept = load_valid && load_ready;

    // NOTE: the value arrays are small register banks, not RAM, so they are cleared on reset too.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending    <= '0;
            shadow_blz <= '0;
            active_blz <= '0;
            for (int d = 0; d < NUM_DISP; d++) begin
                shadow_val[d] <= '0;
                active_val[d] <= '0;
            end
        end else begin
            for (int d = 0; d < NUM_DISP; d++) begin
                if (frame_end && pending[d]) begin
                    active_val[d] <= shadow_val[d];
                    active_blz[d] <= shadow_blz[d];
                    pending[d]    <= 1'b0;
                end else if (accept && load_disp == DW'(d)) begin
                    shadow_val[d] <= load_value;
                    shadow_blz[d] <= load_blank_lz;
                    pending[d]    <= 1'b1;
                end
            end
        end
    end

    // A digit is blanked when blanking is on, it is not digit 0, and it and all higher digits are zero.
    always_comb begin
        an_next  = '0;
        seg_next = '0;
        for (int d = 0; d < NUM_DISP; d++) begin
            if (lit && !(active_blz[d] && di != '0 &&
                         (active_val[d] >> (4 * int'(di))) == '0)) begin
                an_next[d*DIGITS + int'(di)] = 1'b1;
                seg_next[7*d +: 7]           = seg_decode(active_val[d][4*int'(di) +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            anode_en <= {(NUM_DISP*DIGITS){AN_ACTIVE_LOW}};
            seg_out  <= {(NUM_DISP*7){SEG_ACTIVE_LOW}};
        end else begin
            anode_en <= an_next ^ {(NUM_DISP*DIGITS){AN_ACTIVE_LOW}};
            seg_out  <= seg_next ^ {(NUM_DISP*7){SEG_ACTIVE_LOW}};
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_array.sv
// Directed bench for sevenseg_scan_array (3 displays x 4 digits, SCAN_DIV=16); a second
// instance with inverted polarity is driven in parallel and checked against inverted expectations.
module tb_sevenseg_scan_array;
    localparam int ND = 3;
    localparam int DG = 4;
    localparam int SD = 16;
    localparam logic [20:0] ZEROS = {7'h3F, 7'h3F, 7'h3F};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_blank_lz = 1'b0;
    logic [1:0]  load_disp = 2'd0;
    logic [15:0] load_value = 16'h0;
    logic [3:0]  brightness = 4'd15;
    logic        load_ready, ready_i;
    logic [11:0] an, an_i;
    logic [20:0] seg, seg_i;

    int n_checks = 0;
    int n_pass   = 0;
    int pc_m = 0, di_m = 0;
    int out_pc = -1, out_di = -1;

    sevenseg_scan_array #(.NUM_DISP(ND), .DIGITS(DG), .SCAN_DIV(SD),
                          .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_disp(load_disp), .load_value(load_value), .load_blank_lz(load_blank_lz),
        .brightness(brightness), .anode_en(an), .seg_out(seg));

    sevenseg_scan_array #(.NUM_DISP(ND), .DIGITS(DG), .SCAN_DIV(SD),
                          .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_i),
        .load_disp(load_disp), .load_value(load_value), .load_blank_lz(load_blank_lz),
        .brightness(brightness), .anode_en(an_i), .seg_out(seg_i));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_out(input string tag, input logic [11:0] ea, input logic [20:0] es);
        logic [11:0] na;
        logic [20:0] ns;
        na = ~ea;
        ns = ~es;
        check({tag, ".an"}, an, ea);
        check({tag, ".seg"}, seg, es);
        check({tag, ".an_inv"}, an_i, na);
        check({tag, ".seg_inv"}, seg_i, ns);
    endtask

    task automatic check_rdy(input string tag, input logic exp);
        check(tag, load_ready, exp);
        check({tag, ".inv"}, ready_i, exp);
    endtask

    // Advance one clock; out_pc/out_di name the scan position the outputs now show.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            pc_m = 0; di_m = 0; out_pc = -1; out_di = -1;
        end else begin
            out_pc = pc_m;
            out_di = di_m;
            if (pc_m == SD - 1) begin
                pc_m = 0;
                di_m = (di_m + 1) % DG;
            end else begin
                pc_m++;
            end
        end
        #1;
    endtask

    task automatic run_to(input int p, input int d);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(out_pc == p && out_di == d) && n < 200);
        if (n >= 200) begin
            n_checks++;
            $display("FAIL run_to: position (%0d,%0d) not reached", p, d);
        end
    endtask

    task automatic load(input int d, input logic [15:0] v, input logic blz);
        load_disp     = 2'(d);
        load_value    = v;
        load_blank_lz = blz;
        load_valid    = 1'b1;
        tick();
        load_valid    = 1'b0;
    endtask

    task automatic count_lit(input string tag, input int exp);
        int cnt;
        cnt = 0;
        for (int i = 0; i < SD; i++) begin
            tick();
            if (an != '0) cnt++;
        end
        check(tag, 32'(cnt), 32'(exp));
    endtask

    initial begin
        tick(); tick();
        check_out("reset", 12'h000, 21'h0);
        rst = 1'b1;
        tick();
        check_out("scan_d0_first", 12'h111, ZEROS);
        run_to(15, 0); check_out("scan_d0_last", 12'h111, ZEROS);
        run_to(0, 1);  check_out("scan_d1", 12'h222, ZEROS);
        run_to(0, 2);  check_out("scan_d2", 12'h444, ZEROS);

        // Mid-frame load to display 1 stays hidden until the frame boundary.
        load_disp = 2'd1;
        check_rdy("rdy_d1_idle", 1'b1);
        load(1, 16'h1234, 1'b0);
        check_rdy("rdy_d1_pending", 1'b0);
        run_to(0, 3);  check_out("pre_commit", 12'h888, ZEROS);
        run_to(14, 3); check_rdy("rdy_before_commit", 1'b0);
        run_to(15, 3); check_rdy("rdy_after_commit", 1'b1);
        check_out("boundary_old", 12'h888, ZEROS);
        run_to(0, 0);  check_out("d1_dig0", 12'h111, {7'h3F, 7'h66, 7'h3F});
        run_to(0, 1);  check_out("d1_dig1", 12'h222, {7'h3F, 7'h4F, 7'h3F});
        run_to(0, 2);  check_out("d1_dig2", 12'h444, {7'h3F, 7'h5B, 7'h3F});
        run_to(0, 3);  check_out("d1_dig3", 12'h888, {7'h3F, 7'h06, 7'h3F});

        // Blanked 0x0007, display 2 load, rejected second load and out-of-range index.
        load(0, 16'h0007, 1'b1);
        load(2, 16'hABCD, 1'b0);
        load_disp = 2'd2;
        check_rdy("rdy_d2_busy", 1'b0);
        load(2, 16'h5555, 1'b0);
        load_disp = 2'd3;
        check_rdy("rdy_oob", 1'b0);
        load(3, 16'h9999, 1'b0);
        run_to(0, 0);  check_out("lz7_dig0", 12'h111, {7'h5E, 7'h66, 7'h07});
        run_to(0, 1);  check_out("lz7_dig1", 12'h220, {7'h39, 7'h4F, 7'h00});
        run_to(0, 2);  check_out("lz7_dig2", 12'h440, {7'h7C, 7'h5B, 7'h00});
        run_to(0, 3);  check_out("lz7_dig3", 12'h880, {7'h77, 7'h06, 7'h00});

        // All-zero blanked value, then a load landing exactly on the boundary cycle.
        load(0, 16'h0000, 1'b1);
        run_to(14, 3);
        load(1, 16'h0008, 1'b0);
        load_disp = 2'd1;
        check_rdy("rdy_boundary_load", 1'b0);
        run_to(0, 0);  check_out("lz0_dig0", 12'h111, {7'h5E, 7'h66, 7'h3F});
        run_to(0, 1);  check_out("lz0_dig1", 12'h220, {7'h39, 7'h4F, 7'h00});
        run_to(0, 0);  check_out("bnd_dig0", 12'h111, {7'h5E, 7'h7F, 7'h3F});
        run_to(0, 1);  check_out("bnd_dig1", 12'h220, {7'h39, 7'h3F, 7'h00});

        // Brightness changes take effect only at the next slot start.
        run_to(5, 1);
        brightness = 4'd0;
        run_to(15, 1); check_out("bri_midslot", 12'h220, {7'h39, 7'h3F, 7'h00});
        count_lit("bri0_on_cycles", 1);
        brightness = 4'd7;
        count_lit("bri7_on_cycles", 8);

        // Reset mid-frame with a pending load.
        brightness = 4'd15;
        load(1, 16'hFFFF, 1'b0);
        run_to(5, 1);
        rst = 1'b0;
        tick();
        check_out("rst_mid", 12'h000, 21'h0);
        load_disp = 2'd1;
        check_rdy("rdy_after_rst", 1'b1);
        tick();
        rst = 1'b1;
        tick();
        check_out("rst_rel_dig0", 12'h111, ZEROS);
        run_to(0, 1);  check_out("rst_rel_dig1", 12'h222, ZEROS);
        run_to(0, 1);  check_out("rst_no_commit", 12'h222, ZEROS);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
